// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM encoding, default timing and key-map table for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, HOLD = 2'd2} state_t;
  localparam logic [15:0] SCAN_DIV_DEF = 16'd50000;
  localparam logic [3:0]  DB_CNT_DEF   = 4'd4;
  // nibble {row,col} holds the hex code of that key; row 0 is the least significant group
  localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;
  // maps a column index and a single-low row pattern to its hex code
  function automatic logic [3:0] key_code(input logic [1:0] c, input logic [3:0] r);
    logic [1:0] ri;
    ri = !r[0] ? 2'd0 : !r[1] ? 2'd1 : !r[2] ? 2'd2 : 2'd3;
    return KEY_MAP[{ri, c, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/keypad_tick.sv
// keypad_tick: free-running prescaler producing a one-cycle scan tick every SCAN_DIV clocks
module keypad_tick import keypad_pkg::*; #(
  parameter logic [15:0] SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic Clk,
  input  logic Rst,
  output logic tick
);
  logic [15:0] cnt;
  assign tick = cnt == SCAN_DIV - 16'd1;
  // count 0..SCAN_DIV-1 and wrap on the tick cycle
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 16'd1;
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad column scanner with row synchronizer, press/release debounce and key decode
module keypad_scan import keypad_pkg::*; #(
  parameter logic [15:0] SCAN_DIV = SCAN_DIV_DEF,
  parameter logic [3:0]  DB_CNT   = DB_CNT_DEF
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);
  state_t     state, state_n;
  logic       tick, one_low, valid_n, held_n;
  logic [1:0] idx, idx_n;
  logic [3:0] row_m, row_s, cand_row, cand_row_n, cand_key, cand_key_n;
  logic [3:0] mcnt, mcnt_n, rcnt, rcnt_n, key_n;

  keypad_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (.Clk, .Rst, .tick);

  assign col     = ~(4'b0001 << idx);
  assign one_low = $onehot(~row_s);

  // two-flop synchronizer for the asynchronous, idle-high row lines
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      row_m <= '1;
      row_s <= '1;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end

  // next-state: scan until a single row is low, debounce the press, then debounce the release
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    cand_row_n = cand_row;
    cand_key_n = cand_key;
    mcnt_n     = mcnt;
    rcnt_n     = rcnt;
    key_n      = key;
    valid_n    = 1'b0;
    held_n     = key_held;
    if (tick)
      case (state)
        SCAN:
          if (one_low) begin
            cand_row_n = row_s;
            cand_key_n = key_code(idx, row_s);
            mcnt_n     = 4'd1;
            state_n    = DEBOUNCE;
          end else idx_n = idx + 2'd1;
        DEBOUNCE:
          if (row_s == cand_row) mcnt_n = mcnt + 4'd1;
          else begin
            state_n = SCAN;
            idx_n   = idx + 2'd1;
          end
        HOLD: begin
          rcnt_n = (row_s == 4'hF) ? rcnt + 4'd1 : 4'd0;
          if (rcnt_n == DB_CNT) begin
            state_n = SCAN;
            idx_n   = idx + 2'd1;
            held_n  = 1'b0;
            rcnt_n  = 4'd0;
          end
        end
        default: state_n = SCAN;
      endcase
    if (state_n == DEBOUNCE && mcnt_n == DB_CNT) begin
      state_n = HOLD;
      key_n   = cand_key_n;
      valid_n = 1'b1;
      held_n  = 1'b1;
      rcnt_n  = 4'd0;
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state     <= SCAN;
      idx       <= '0;
      cand_row  <= '1;
      cand_key  <= '0;
      mcnt      <= '0;
      rcnt      <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cand_row  <= cand_row_n;
      cand_key  <= cand_key_n;
      mcnt      <= mcnt_n;
      rcnt      <= rcnt_n;
      key       <= key_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed self-checking bench with a keypad model and an expected-key scoreboard
module tb_keypad_scan;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       press_en = 1'b0, ghost_en = 1'b0;
  logic [1:0] press_r = 2'd0, press_c = 2'd0;
  logic [3:0] row, col, key;
  logic       key_valid, key_held;
  int         checks = 0, failures = 0, pulses = 0, p0 = 0;
  logic [3:0] exp_q[$];

  assign row = (ghost_en && !col[0]) ? 4'b1100 :
               (press_en && !col[press_c]) ? ~(4'b0001 << press_r) : 4'b1111;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_DIV(16'd4), .DB_CNT(4'd3)) dut (
    .Clk(clk), .Rst(rst_n), .row(row), .col(col),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_tick(input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      k = 0;
      @(negedge clk);
      while (dut.tick !== 1'b1 && k < 16) begin
        @(negedge clk);
        k++;
      end
      if (dut.tick !== 1'b1) begin
        checks++;
        failures++;
        $error("FAIL tick_timeout: got no tick expected one within 16 cycles");
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_col(input logic [3:0] target);
    int k;
    k = 0;
    while (col === target && k < 64) begin
      @(negedge clk);
      k++;
    end
    while (col !== target && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (col !== target) begin
      checks++;
      failures++;
      $error("FAIL col_timeout: got %h expected %h", col, target);
    end
  endtask

  // every key_valid pulse must match the oldest expected key
  always @(negedge clk)
    if (rst_n && key_valid === 1'b1) begin
      pulses++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL pulse_unexpected: got key %h expected no pulse", key);
      end
      if (exp_q.size() != 0) chk("pulse_key", key, exp_q.pop_front());
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e;
    // reset values during reset
    #23;
    chk("rst_col", col, 4'b1110);
    chk("rst_key", key, 4'h0);
    chk("rst_valid", {3'b000, key_valid}, 4'd0);
    chk("rst_held", {3'b000, key_held}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // column walk: one step every 4 clocks from column 0
    for (int p = 1; p <= 16; p++) begin
      @(negedge clk);
      e = 4'b0001 << ((p / 4) % 4);
      chk("walk_col", col, ~e);
    end
    chk("walk_valid", {3'b000, key_valid}, 4'd0);
    chk("walk_key", key, 4'h0);

    // press '5' (row1, col1)
    wait_col(4'b1101);
    p0 = pulses;
    press_r = 2'd1; press_c = 2'd1; press_en = 1'b1;
    exp_q.push_back(4'h5);
    wait_tick(2);
    chk("press_no_early", {3'b000, key_valid}, 4'd0);
    wait_tick(1);
    chk("press_valid", {3'b000, key_valid}, 4'd1);
    chk("press_key", key, 4'h5);
    chk("press_held", {3'b000, key_held}, 4'd1);
    @(posedge clk); #1;
    chk("press_pulse_end", {3'b000, key_valid}, 4'd0);
    wait_tick(4);
    chk("hold_col", col, 4'b1101);
    press_en = 1'b0;
    wait_tick(2);
    chk("release_still_held", {3'b000, key_held}, 4'd1);
    wait_tick(1);
    chk("release_held", {3'b000, key_held}, 4'd0);
    chk("release_key", key, 4'h5);
    chk("release_col", col, 4'b1011);
    chk("press_pulses", 4'(pulses - p0), 4'd1);

    // bounce: two matching samples then release
    wait_col(4'b1101);
    p0 = pulses;
    press_r = 2'd2; press_c = 2'd1; press_en = 1'b1;
    wait_tick(1);
    chk("bounce_frozen", col, 4'b1101);
    wait_tick(1);
    press_en = 1'b0;
    wait_tick(1);
    chk("bounce_col", col, 4'b1011);
    wait_tick(1);
    chk("bounce_scan", col, 4'b0111);
    chk("bounce_pulses", 4'(pulses - p0), 4'd0);

    // ghost: two rows low in column 0 must not stop scanning
    wait_col(4'b1101);
    p0 = pulses;
    ghost_en = 1'b1;
    for (int t = 2; t < 10; t++) begin
      wait_tick(1);
      e = 4'b0001 << (t % 4);
      chk("ghost_col", col, ~e);
    end
    ghost_en = 1'b0;
    chk("ghost_pulses", 4'(pulses - p0), 4'd0);

    // long press 'D' (row3, col3) for 100 ticks
    wait_col(4'b0111);
    p0 = pulses;
    press_r = 2'd3; press_c = 2'd3; press_en = 1'b1;
    exp_q.push_back(4'hD);
    wait_tick(3);
    chk("long_valid", {3'b000, key_valid}, 4'd1);
    chk("long_key", key, 4'hD);
    wait_tick(97);
    chk("long_pulses", 4'(pulses - p0), 4'd1);
    chk("long_held", {3'b000, key_held}, 4'd1);
    chk("long_col", col, 4'b0111);
    press_en = 1'b0;
    wait_tick(3);
    chk("long_release", {3'b000, key_held}, 4'd0);
    chk("long_key_kept", key, 4'hD);

    // reset in the middle of debounce, then a normal press of '9'
    wait_col(4'b1011);
    p0 = pulses;
    press_r = 2'd2; press_c = 2'd2; press_en = 1'b1;
    wait_tick(2);
    chk("mid_frozen", col, 4'b1011);
    rst_n = 1'b0;
    #2;
    chk("mid_col", col, 4'b1110);
    chk("mid_key", key, 4'h0);
    chk("mid_valid", {3'b000, key_valid}, 4'd0);
    chk("mid_held", {3'b000, key_held}, 4'd0);
    press_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_resume_col", col, 4'b1110);
    chk("mid_pulses", 4'(pulses - p0), 4'd0);
    wait_col(4'b1011);
    press_en = 1'b1;
    exp_q.push_back(4'h9);
    wait_tick(3);
    chk("after_valid", {3'b000, key_valid}, 4'd1);
    chk("after_key", key, 4'h9);
    chk("after_held", {3'b000, key_held}, 4'd1);
    press_en = 1'b0;
    wait_tick(3);
    chk("after_release", {3'b000, key_held}, 4'd0);
    chk("after_pulses", 4'(pulses - p0), 4'd1);
    chk("queue_empty", 4'(exp_q.size()), 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SCAN_DIV, 16'd50000, Clk cycles per scan tick (minimum 2).
REQ-002 DB_CNT, 4'd4, consecutive matching tick samples needed to accept a press or a release (minimum 1).
REQ-003 Clk  input  1  system clock, rising edge.
REQ-004 Rst  input  1  asynchronous active-low reset.
REQ-005 row  input  4  keypad row lines, active-low, external pull-ups, asynchronous to Clk.
REQ-006 col  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 key  output  4  hex code of the last accepted key.
REQ-008 key_valid  output  1  one-cycle pulse when a new key is accepted.
REQ-009 key_held  output  1  high from acceptance until the release is accepted.

Function
REQ-010 The row inputs SHALL pass through a 2-flop synchronizer, and every sample SHALL use the synchronized value.
REQ-011 The prescaler SHALL count 0..SCAN_DIV-1 and wrap, and SHALL assert tick for one cycle when the count equals SCAN_DIV-1.
REQ-012 col SHALL equal ~(4'b0001 << idx), where idx is a 2-bit column index that wraps 3->0.
REQ-013 The FSM SHALL have exactly three states: SCAN, DEBOUNCE, HOLD.
REQ-014 SCAN state: on tick, if exactly one synchronized row bit is low, the block SHALL latch the candidate code from {idx,row}, set the match count to 1, and go to DEBOUNCE; otherwise idx SHALL advance.
REQ-015 In DEBOUNCE and HOLD, idx and col SHALL be frozen.
REQ-016 DEBOUNCE state: on tick, if the same single row is low, the match count SHALL increment; otherwise the state SHALL return to SCAN and idx SHALL advance.
REQ-017 When the match count reaches DB_CNT, the block SHALL update key, pulse key_valid in the next cycle, and enter HOLD; with DB_CNT=1 acceptance SHALL occur on the first sample.
REQ-018 HOLD state: each tick with all rows high SHALL increment the release count, and any low row SHALL clear it.
REQ-019 When the release count reaches DB_CNT, the FSM SHALL go to SCAN, advance idx, and deassert key_held.
REQ-020 Key map (row r, col c): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: 0 F E D.
REQ-021 Two or more rows low in the scanned column SHALL be treated as no key (no candidate, no acceptance).
REQ-022 A key held indefinitely SHALL produce exactly one key_valid pulse.
REQ-023 key SHALL hold its value until the next acceptance; release SHALL NOT change key.
REQ-024 key_valid and key_held SHALL be registered outputs.

Reset
REQ-025 On Rst low, state SHALL be SCAN, idx 0, col 4'b1110, key 4'h0, key_valid 0, key_held 0, prescaler/match/release counts 0, and synchronizer flops 4'b1111.
REQ-026 Reset asserted mid-DEBOUNCE or mid-HOLD SHALL abort the operation with no key_valid pulse.
REQ-027 After reset release, scanning SHALL resume from column 0.

Structure
REQ-028 The key-map table, FSM state encodings, and SCAN_DIV/DB_CNT defaults SHALL reside in a shared package (keypad_pkg).
REQ-029 The prescaler SHALL be a sub-module named keypad_tick (ports Clk, Rst, tick; parameter SCAN_DIV).
REQ-030 Synchronizer, FSM, and output registers SHALL stay in keypad_scan.

Verification (SCAN_DIV=4, DB_CNT=3)
REQ-031 Reset test: during and after reset, col=4'b1110, key=0, key_valid=0, key_held=0; col then cycles 1110->1101->1011->0111 every 4 clocks.
REQ-032 Press test: hold row=4'b1101 while col=4'b1101 (key '5') -> exactly one key_valid pulse with key=4'h5 after 3 ticks and key_held=1; release -> key_held=0 after 3 quiet ticks, key stays 4'h5.
REQ-033 Bounce test: row low for 2 ticks then high -> no key_valid, FSM back in SCAN, col advances.
REQ-034 Ghost test: row=4'b1100 in column 0 -> no key_valid and scanning continues uninterrupted.
REQ-035 Long-press test: key 'D' (row3, col3) held for 100 ticks -> exactly one pulse with key=4'hD.
REQ-036 Mid-operation reset test: Rst pulsed low in DEBOUNCE -> all outputs return to reset values with no pulse; a subsequent valid press is accepted normally.
